// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with programmable almost-full/almost-empty
// thresholds, registered occupancy count, sticky overflow/underflow errors and
// a selectable standard (registered) or first-word-fall-through read port.
module sync_fifo_prog #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int SIZE  = $clog2(DEPTH),
  parameter int FWFT  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             rd_valid,
  input  logic [SIZE:0]    af_level,
  input  logic [SIZE:0]    ae_level,
  input  logic             err_clr,
  output logic [SIZE:0]    count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow
);

  localparam int            CW      = SIZE + 1;
  localparam logic [SIZE:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SIZE:0] ONE_C   = CW'(1);

  // Storage array; deliberately not reset so it maps onto plain RAM.
  logic [WIDTH-1:0] mem [DEPTH];

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [SIZE:0] wr_ptr_q, wr_ptr_d;
  logic [SIZE:0] rd_ptr_q, rd_ptr_d;
  logic [SIZE:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          almost_full_q, almost_full_d;
  logic          almost_empty_q, almost_empty_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic          rd_acc;
  logic          wr_acc;

  // Accept logic: a read frees a slot, so a write at full is still taken
  // when paired with an accepted read; a read at empty is always refused.
  always_comb begin
    rd_acc = rd_en && !empty_q;
    wr_acc = wr_en && (!full_q || rd_acc);
  end

  // Next-state pointers, occupancy and flags, all judged on the post-edge count.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ONE_C;
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + ONE_C;
    end
    count_d        = wr_ptr_d - rd_ptr_d;
    full_d         = (count_d == DEPTH_C);
    empty_d        = (count_d == '0);
    almost_full_d  = (count_d >= af_level) && !full_d;
    almost_empty_d = (count_d <= ae_level) && !empty_d;
  end

  // Sticky error flags: a new error event takes priority over a clear.
  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (err_clr) begin
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end
    if (wr_en && !wr_acc) begin
      overflow_d = 1'b1;
    end
    if (rd_en && !rd_acc) begin
      underflow_d = 1'b1;
    end
  end

  // Control and status registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      full_q         <= full_d;
      empty_q        <= empty_d;
      almost_full_q  <= almost_full_d;
      almost_empty_q <= almost_empty_d;
      overflow_q     <= overflow_d;
      underflow_q    <= underflow_d;
    end
  end

  // Memory write port.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q[SIZE-1:0]] <= wr_data;
    end
  end

  assign count        = count_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = almost_full_q;
  assign almost_empty = almost_empty_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  generate
    if (FWFT == 0) begin : g_std
      logic [WIDTH-1:0] rd_data_q, rd_data_d;
      logic             rd_valid_q, rd_valid_d;

      // Registered read: capture the head on an accepted read, else hold.
      always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_acc;
        if (rd_acc) begin
          rd_data_d = mem[rd_ptr_q[SIZE-1:0]];
        end
      end

      // Read data register, cleared on reset.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rd_data_q  <= '0;
          rd_valid_q <= 1'b0;
        end else begin
          rd_data_q  <= rd_data_d;
          rd_valid_q <= rd_valid_d;
        end
      end

      assign rd_data  = rd_data_q;
      assign rd_valid = rd_valid_q;
    end else begin : g_fwft
      // Head word is always presented; forced to zero while nothing is held
      // so the output is clean during and after reset.
      assign rd_valid = !empty_q;
      assign rd_data  = empty_q ? '0 : mem[rd_ptr_q[SIZE-1:0]];
    end
  endgenerate

endmodule
